// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: synthetic OV5640-style DVP source emitting RGB565 test patterns, high byte first.
// Optional macro DVP_TX_SCROLL_EN: gradient/checkerboard scroll one column per frame.
module dvp_pattern_tx #(
  parameter int H_PIXEL  = 1280,
  parameter int V_PIXEL  = 720,
  parameter int H_BLANK  = 10,
  parameter int VS_LINES = 4,
  parameter int V_FRONT  = 20,
  parameter int V_BACK   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [1:0] pat_sel,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       busy,
  output logic       frame_done
);
  // state    | meaning
  // S_IDLE   | waiting for tx_en, outputs quiet
  // S_VSYNC  | VS_LINES line periods with vsync high
  // S_VFRONT | V_FRONT blank lines before video
  // S_ACTIVE | V_PIXEL lines carrying pixel bytes
  // S_VBACK  | V_BACK blank lines; last cycle flags frame_done

  localparam int LINE_LEN = 2 * H_PIXEL + H_BLANK;
  localparam int BAR_W    = H_PIXEL / 8;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VFRONT, S_ACTIVE, S_VBACK} state_t;

  state_t      state, state_n;
  logic [11:0] h_cnt, h_n;
  logic [10:0] l_cnt, l_n, last_line;
  logic [1:0]  pat_q, pat_n;
  logic [2:0]  bar_idx, bar_idx_n;
  logic [7:0]  bar_cnt, bar_cnt_n;
  logic [5:0]  x_eff;
  logic [15:0] bar_pix, pix;
  logic        last_n, href_n;
  logic [7:0]  data_n;

  always_comb begin
    case (state)
      S_VSYNC:  last_line = 11'(VS_LINES - 1);
      S_VFRONT: last_line = 11'(V_FRONT - 1);
      S_ACTIVE: last_line = 11'(V_PIXEL - 1);
      S_VBACK:  last_line = 11'(V_BACK - 1);
      default:  last_line = '0;
    endcase
  end

  // Outputs are registered from the position the next cycle will occupy,
  // so they line up with state/counters without an extra pipeline stage.
  always_comb begin
    state_n = state;
    h_n     = h_cnt;
    l_n     = l_cnt;
    pat_n   = pat_q;
    if (state == S_IDLE) begin
      h_n = '0;
      l_n = '0;
      if (tx_en) begin
        state_n = S_VSYNC;
        pat_n   = pat_sel;
      end
    end else if (h_cnt != 12'(LINE_LEN - 1)) begin
      h_n = h_cnt + 12'd1;
    end else begin
      h_n = '0;
      if (l_cnt != last_line) begin
        l_n = l_cnt + 11'd1;
      end else begin
        l_n = '0;
        case (state)
          S_VSYNC:  state_n = S_VFRONT;
          S_VFRONT: state_n = S_ACTIVE;
          S_ACTIVE: state_n = S_VBACK;
          default: begin
            if (tx_en) begin
              state_n = S_VSYNC;
              pat_n   = pat_sel;
            end else begin
              state_n = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign last_n = (state_n == S_VBACK) && (l_n == 11'(V_BACK - 1)) &&
                  (h_n == 12'(LINE_LEN - 1));

  // Bar tracking: down-counter per bar, advanced on each new pixel column.
  always_comb begin
    bar_idx_n = bar_idx;
    bar_cnt_n = bar_cnt;
    if (h_n == '0) begin
      bar_idx_n = '0;
      bar_cnt_n = 8'(BAR_W - 1);
    end else if (!h_n[0]) begin
      if (bar_cnt == '0) begin
        bar_idx_n = bar_idx + 3'd1;
        bar_cnt_n = 8'(BAR_W - 1);
      end else begin
        bar_cnt_n = bar_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    case (bar_idx_n)
      3'd0:    bar_pix = 16'hFFFF;
      3'd1:    bar_pix = 16'hFFE0;
      3'd2:    bar_pix = 16'h07FF;
      3'd3:    bar_pix = 16'h07E0;
      3'd4:    bar_pix = 16'hF81F;
      3'd5:    bar_pix = 16'hF800;
      3'd6:    bar_pix = 16'h001F;
      default: bar_pix = 16'h0000;
    endcase
  end

`ifdef DVP_TX_SCROLL_EN
  logic [10:0] frame_cnt;
  always_ff @(posedge clk) begin
    if (rst)         frame_cnt <= '0;
    else if (last_n) frame_cnt <= frame_cnt + 11'd1;
  end
  assign x_eff = h_n[6:1] + frame_cnt[5:0];
`else
  assign x_eff = h_n[6:1];
`endif

  always_comb begin
    case (pat_n)
      2'd0:    pix = bar_pix;
      2'd1:    pix = {x_eff[4:0], x_eff[5:0], l_n[4:0]};
      2'd2:    pix = (x_eff[5] ^ l_n[5]) ? 16'hFFFF : 16'h0000;
      default: pix = 16'hF800;
    endcase
  end

  assign href_n = (state_n == S_ACTIVE) && (h_n < 12'(2 * H_PIXEL));
  assign data_n = !href_n ? 8'h00 : (h_n[0] ? pix[7:0] : pix[15:8]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      h_cnt      <= '0;
      l_cnt      <= '0;
      pat_q      <= '0;
      bar_idx    <= '0;
      bar_cnt    <= '0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      h_cnt      <= h_n;
      l_cnt      <= l_n;
      pat_q      <= pat_n;
      bar_idx    <= bar_idx_n;
      bar_cnt    <= bar_cnt_n;
      cam_vsync  <= (state_n == S_VSYNC);
      cam_href   <= href_n;
      cam_data   <= data_n;
      busy       <= (state_n != S_IDLE);
      frame_done <= last_n;
    end
  end
endmodule
